// File: rtl/cla_pkg.sv
// Shared types and constants for the sequential carry-lookahead adder.
package cla_pkg;

    localparam int SLICE_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cla_16.sv
// 16-bit carry-lookahead slice: four 4-bit groups with group-level lookahead.
module cla_16
    import cla_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               c0,
    output logic [SLICE_W-1:0] s,
    output logic               cy,
    output logic               p,
    output logic               g
);

    logic [SLICE_W-1:0] pb;
    logic [SLICE_W-1:0] gb;
    logic [3:0]         gp;
    logic [3:0]         gg;

    assign pb = a ^ b;
    assign gb = a & b;

    always_comb begin
        gp = '0;
        gg = '0;
        for (int j = 0; j < 4; j++) begin
            gp[j] = &pb[4*j +: 4];
            gg[j] = gb[4*j+3]
                  | (pb[4*j+3] & gb[4*j+2])
                  | (pb[4*j+3] & pb[4*j+2] & gb[4*j+1])
                  | (pb[4*j+3] & pb[4*j+2] & pb[4*j+1] & gb[4*j]);
        end
    end

    // Group carries come from lookahead; only bits inside a group ripple.
    always_comb begin
        logic gc;
        logic bc;
        s  = '0;
        gc = c0;
        bc = 1'b0;
        for (int j = 0; j < 4; j++) begin
            bc = gc;
            for (int i = 0; i < 4; i++) begin
                s[4*j+i] = pb[4*j+i] ^ bc;
                bc = gb[4*j+i] | (pb[4*j+i] & bc);
            end
            gc = gg[j] | (gp[j] & gc);
        end
        cy = gc;
    end

    assign p = &gp;
    assign g = gg[3]
             | (gp[3] & gg[2])
             | (gp[3] & gp[2] & gg[1])
             | (gp[3] & gp[2] & gp[1] & gg[0]);

endmodule

// File: rtl/cla_seq_add64.sv
// Multi-cycle WIDTH-bit adder feeding one cla_16 slice per cycle, LSB first.
// Optional subtract mode and signed overflow flag under CLA_SEQ_SUB_EN.
module cla_seq_add64
    import cla_pkg::*;
#(
    parameter int WIDTH = 64
) (
`ifdef CLA_SEQ_SUB_EN
    input  logic             sub,
    output logic             ovf,
`endif
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int NSLICE = WIDTH / SLICE_W;
    localparam int CW     = cnt_w(NSLICE);
    localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

    if ((WIDTH % SLICE_W) != 0 || WIDTH < SLICE_W) begin : g_bad_width
        $fatal(1, "cla_seq_add64: WIDTH must be a multiple of 16 and >= 16");
    end

    state_e                           state_q;
    logic [CW-1:0]                    cnt_q;
    logic                             carry_q;
    logic                             cout_q;
    logic [NSLICE-1:0][SLICE_W-1:0]   a_q;
    logic [NSLICE-1:0][SLICE_W-1:0]   b_q;
    logic [NSLICE-1:0][SLICE_W-1:0]   sum_q;
    logic [NSLICE-1:0][SLICE_W-1:0]   b_d;
    logic                             carry_d;
    logic [SLICE_W-1:0]               s;
    logic                             cy;
    logic                             accept;

    assign accept = in_valid && in_ready;

`ifdef CLA_SEQ_SUB_EN
    assign b_d     = sub ? ~b : b;
    assign carry_d = sub ? 1'b1 : cin;
`else
    assign b_d     = b;
    assign carry_d = cin;
`endif

    // Operands carry no reset: they are always loaded before use.
    always_ff @(posedge clk) begin
        if (state_q == IDLE && accept) begin
            a_q <= a;
            b_q <= b_d;
        end
    end

    cla_16 u_cla (
        .a  (a_q[cnt_q]),
        .b  (b_q[cnt_q]),
        .c0 (carry_q),
        .s  (s),
        .cy (cy),
        .p  (),
        .g  ()
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            sum_q     <= '0;
            cout_q    <= 1'b0;
            cnt_q     <= '0;
            carry_q   <= 1'b0;
`ifdef CLA_SEQ_SUB_EN
            ovf       <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        carry_q  <= carry_d;
                        cnt_q    <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state_q  <= RUN;
                    end
                end
                RUN: begin
                    sum_q[cnt_q] <= s;
                    carry_q      <= cy;
                    cnt_q        <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        cout_q    <= cy;
                        out_valid <= 1'b1;
                        state_q   <= DONE;
`ifdef CLA_SEQ_SUB_EN
                        ovf <= (a_q[NSLICE-1][SLICE_W-1] ==
                                b_q[NSLICE-1][SLICE_W-1]) &&
                               (s[SLICE_W-1] != a_q[NSLICE-1][SLICE_W-1]);
`endif
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_cla_seq_add64.sv
// Randomized self-checking bench for cla_seq_add64 against a 65-bit model.
module tb_cla_seq_add64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] a = '0;
    logic [63:0] b = '0;
    logic        cin = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] sum;
    logic        cout;
    logic        busy;
`ifdef CLA_SEQ_SUB_EN
    logic        sub = 1'b0;
    logic        ovf;
`endif

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    cla_seq_add64 #(.WIDTH(64)) dut (
`ifdef CLA_SEQ_SUB_EN
        .sub       (sub),
        .ovf       (ovf),
`endif
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [63:0] ta, input logic [63:0] tb,
                        input logic tc);
        a = ta;
        b = tb;
        cin = tc;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // Cycles from the accept edge until out_valid; -1 on timeout.
    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 50) begin
            tick();
            cyc++;
        end
        if (!out_valid) cyc = -1;
    endtask

    function automatic logic [64:0] ref_add(input logic [63:0] x,
                                            input logic [63:0] y,
                                            input logic c);
        return {1'b0, x} + {1'b0, y} + {64'd0, c};
    endfunction

    task automatic test_reset();
        int cyc;
        int seen;
        rst_n = 1'b0;
        tick();
        tick();
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 ||
            sum !== 64'd0 || cout !== 1'b0) begin
            bad++;
            $display("FAIL reset_init: rdy=%b vld=%b busy=%b sum=%h cout=%b want 1 0 0 0 0",
                     in_ready, out_valid, busy, sum, cout);
        end
        rst_n = 1'b1;
        tick();
        send(64'h1234_5678_9abc_def0, 64'h1111_2222_3333_4444, 1'b1);
        tick();
        rst_n = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 ||
            sum !== 64'd0 || cout !== 1'b0) begin
            bad++;
            $display("FAIL reset_midrun: rdy=%b vld=%b busy=%b sum=%h cout=%b want 1 0 0 0 0",
                     in_ready, out_valid, busy, sum, cout);
        end
        tick();
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid || busy) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL reset_noresult: active_cycles=%0d want 0", seen);
        end
        cyc = 0;
    endtask

    task automatic test_basic();
        int cyc;
        send(64'h1, 64'h2, 1'b0);
        wait_valid(cyc);
        total++;
        if (cyc != 4) begin
            bad++;
            $display("FAIL basic_latency: got=%0d want=4", cyc);
        end
        total++;
        if (sum !== 64'h3 || cout !== 1'b0) begin
            bad++;
            $display("FAIL basic_sum: got=%h/%b want=3/0", sum, cout);
        end
        total++;
        if (in_ready !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL basic_done_flags: rdy=%b busy=%b want 0 1", in_ready, busy);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 ||
            sum !== 64'h3) begin
            bad++;
            $display("FAIL basic_release: vld=%b rdy=%b busy=%b sum=%h want 0 1 0 3",
                     out_valid, in_ready, busy, sum);
        end
    endtask

    task automatic test_ripple();
        int cyc;
        send(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1);
        wait_valid(cyc);
        total++;
        if (cyc != 4 || sum !== 64'h0 || cout !== 1'b1) begin
            bad++;
            $display("FAIL ripple: lat=%0d sum=%h cout=%b want 4/0/1", cyc, sum, cout);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int          cyc;
        int          drift;
        logic [63:0] x;
        logic [63:0] y;
        logic [64:0] exp1;
        logic [64:0] exp2;
        x = {$urandom, $urandom};
        y = {$urandom, $urandom};
        exp1 = ref_add(x, y, 1'b0);
        send(x, y, 1'b0);
        wait_valid(cyc);
        total++;
        if (cyc < 0 || {cout, sum} !== exp1) begin
            bad++;
            $display("FAIL bp_first: got=%h want=%h", {cout, sum}, exp1);
        end
        a = ~x;
        b = 64'h5555_0000_aaaa_0001;
        cin = 1'b1;
        exp2 = ref_add(a, b, 1'b1);
        in_valid = 1'b1;
        drift = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if ({cout, sum} !== exp1 || in_ready !== 1'b0 || out_valid !== 1'b1)
                drift++;
        end
        total++;
        if (drift != 0) begin
            bad++;
            $display("FAIL bp_hold: unstable_cycles=%0d want 0", drift);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        total++;
        if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL bp_handshake: busy=%b rdy=%b vld=%b want 0 1 0",
                     busy, in_ready, out_valid);
        end
        tick();
        in_valid = 1'b0;
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL bp_capture: busy=%b want 1", busy);
        end
        wait_valid(cyc);
        total++;
        if (cyc != 4 || {cout, sum} !== exp2) begin
            bad++;
            $display("FAIL bp_second: lat=%0d got=%h want 4/%h", cyc, {cout, sum}, exp2);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        int          cyc;
        int          errs;
        int          accepts;
        int          results;
        logic [63:0] x;
        logic [63:0] y;
        logic [63:0] ye;
        logic        c;
        logic        ce;
        logic        s;
        logic [64:0] exp;
        errs = 0;
        accepts = 0;
        results = 0;
        for (int n = 0; n < 3000; n++) begin
            x = {$urandom, $urandom};
            y = {$urandom, $urandom};
            if (n % 7 == 0) y = ~x;
            c = 1'($urandom);
            s = 1'b0;
`ifdef CLA_SEQ_SUB_EN
            s = 1'($urandom);
            sub = s;
`endif
            ye = s ? ~y : y;
            ce = s ? 1'b1 : c;
            exp = ref_add(x, ye, ce);
            send(x, y, c);
            accepts++;
            out_ready = 1'($urandom);
            tick();
            out_ready = 1'b0;
            wait_valid(cyc);
            if (cyc < 0) begin
                errs++;
            end else begin
                results++;
                if ({cout, sum} !== exp) errs++;
`ifdef CLA_SEQ_SUB_EN
                if (ovf !== ((x[63] == ye[63]) && (exp[63] != x[63]))) errs++;
`endif
            end
            for (int g = $urandom_range(0, 3); g > 0; g--) tick();
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            if (out_valid !== 1'b0) errs++;
        end
`ifdef CLA_SEQ_SUB_EN
        sub = 1'b0;
`endif
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL random: errors=%0d want 0", errs);
        end
        total++;
        if (accepts != results) begin
            bad++;
            $display("FAIL random_count: results=%0d want %0d", results, accepts);
        end
    endtask

`ifdef CLA_SEQ_SUB_EN
    task automatic test_sub();
        int cyc;
        sub = 1'b1;
        send(64'd5, 64'd7, 1'b0);
        wait_valid(cyc);
        total++;
        if (sum !== 64'hFFFF_FFFF_FFFF_FFFE || cout !== 1'b0 || ovf !== 1'b0) begin
            bad++;
            $display("FAIL sub_5_7: got=%h/%b/%b want fffffffffffffffe/0/0", sum, cout, ovf);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        send(64'h8000_0000_0000_0000, 64'd1, 1'b0);
        wait_valid(cyc);
        total++;
        if (sum !== 64'h7FFF_FFFF_FFFF_FFFF || cout !== 1'b1 || ovf !== 1'b1) begin
            bad++;
            $display("FAIL sub_ovf: got=%h/%b/%b want 7fffffffffffffff/1/1", sum, cout, ovf);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        sub = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_ripple();
        test_backpressure();
`ifdef CLA_SEQ_SUB_EN
        test_sub();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
